// File: rtl/gba_pkg.sv
// Shared GBA bus definitions: transfer width codes, DMA address-control codes,
// DMA3 register offsets and CNT_H bit positions.
package gba_pkg;

  localparam logic [1:0] W_BYTE = 2'd0;
  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;

  localparam logic [1:0] AC_INC        = 2'd0;
  localparam logic [1:0] AC_DEC        = 2'd1;
  localparam logic [1:0] AC_FIXED      = 2'd2;
  localparam logic [1:0] AC_INC_RELOAD = 2'd3;

  localparam logic [23:0] DMA3_BASE = 24'h0000D4;
  localparam logic [23:0] OFS_SAD   = 24'd0;
  localparam logic [23:0] OFS_DAD   = 24'd4;
  localparam logic [23:0] OFS_CNT   = 24'd8;

  localparam int CNTH_DST_LO = 5;
  localparam int CNTH_SRC_LO = 7;
  localparam int CNTH_WORD   = 10;
  localparam int CNTH_IRQ    = 14;
  localparam int CNTH_EN     = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } dma_state_e;

endpackage

// File: rtl/dma_addr_step.sv
// Next DMA address for one unit: +/- 2 or 4 bytes, or unchanged, with 32-bit wrap.
module dma_addr_step
  import gba_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [1:0]  ctrl,
  input  logic        word,
  output logic [31:0] next_addr
);

  logic [31:0] delta;

  always_comb begin
    delta = word ? 32'd4 : 32'd2;
    case (ctrl)
      AC_DEC:   next_addr = addr - delta;
      AC_FIXED: next_addr = addr;
      default:  next_addr = addr + delta;
    endcase
  end

endmodule

// File: rtl/dma_channel.sv
// Single DMA channel with the DMA3 register layout, acting as bus initiator.
// Copies COUNT half/word units (read then write), then clears enable and may pulse irq.
module dma_channel
  import gba_pkg::*;
#(
  parameter logic [23:0] REG_BASE = DMA3_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] io_addr,
  input  logic [31:0] io_data_in,
  input  logic [1:0]  io_width,
  input  logic        io_write,
  input  logic        io_read,
  output logic [31:0] io_data_out,
  output logic        dma_req,
  input  logic        dma_gnt,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  bus_width,
  output logic        bus_read,
  output logic        bus_write,
  input  logic        bus_ok,
  output logic        irq
);

  logic [31:0] sad_q, sad_d, dad_q, dad_d;
  logic [15:0] cnt_l_q, cnt_l_d, cnt_h_q, cnt_h_d;
  dma_state_e  state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d, data_q, data_d;
  logic [16:0] rem_q, rem_d;
  logic        rd_seen_q, rd_seen_d, word_q, word_d;
  logic [1:0]  src_ctrl_q, src_ctrl_d, dst_ctrl_q, dst_ctrl_d;
  logic [31:0] src_step, dst_step, rd_word, rd_shift;
  logic [23:0] io_word_addr;
  logic        sel_sad, sel_dad, sel_cnt, start, new_word;

  assign io_word_addr = {io_addr[23:2], 2'b00};
  assign sel_sad = (io_word_addr == REG_BASE + OFS_SAD);
  assign sel_dad = (io_word_addr == REG_BASE + OFS_DAD);
  assign sel_cnt = (io_word_addr == REG_BASE + OFS_CNT);

  // Register file; the CPU write is applied after DONE's enable clear so it wins.
  always_comb begin
    sad_d   = sad_q;
    dad_d   = dad_q;
    cnt_l_d = cnt_l_q;
    cnt_h_d = cnt_h_q;
    if (state_q == ST_DONE) cnt_h_d[CNTH_EN] = 1'b0;
    if (io_write && io_width == W_WORD && io_addr[1:0] == 2'b00) begin
      if (sel_sad) sad_d = io_data_in;
      if (sel_dad) dad_d = io_data_in;
      if (sel_cnt) begin
        cnt_l_d = io_data_in[15:0];
        cnt_h_d = io_data_in[31:16];
      end
    end else if (io_write && io_width == W_HALF && !io_addr[0]) begin
      if (sel_sad && io_addr[1])  sad_d[31:16] = io_data_in[15:0];
      if (sel_sad && !io_addr[1]) sad_d[15:0]  = io_data_in[15:0];
      if (sel_dad && io_addr[1])  dad_d[31:16] = io_data_in[15:0];
      if (sel_dad && !io_addr[1]) dad_d[15:0]  = io_data_in[15:0];
      if (sel_cnt && io_addr[1])  cnt_h_d      = io_data_in[15:0];
      if (sel_cnt && !io_addr[1]) cnt_l_d      = io_data_in[15:0];
    end
  end

  always_comb begin
    rd_word = 32'h0;
    if (sel_sad) rd_word = sad_q;
    if (sel_dad) rd_word = dad_q;
    if (sel_cnt) rd_word = {cnt_h_q, cnt_l_q};
    rd_shift    = rd_word >> {io_addr[1:0], 3'b000};
    io_data_out = 32'h0;
    if (io_read) begin
      case (io_width)
        W_BYTE:  io_data_out = {24'h0, rd_shift[7:0]};
        W_HALF:  io_data_out = {16'h0, rd_shift[15:0]};
        W_WORD:  io_data_out = rd_word;
        default: io_data_out = 32'h0;
      endcase
    end
  end

  assign start    = (state_q == ST_IDLE) && cnt_h_d[CNTH_EN] && !cnt_h_q[CNTH_EN];
  assign new_word = cnt_h_d[CNTH_WORD];

  dma_addr_step u_src_step (
    .addr      (src_q),
    .ctrl      (src_ctrl_q),
    .word      (word_q),
    .next_addr (src_step)
  );

  dma_addr_step u_dst_step (
    .addr      (dst_q),
    .ctrl      (dst_ctrl_q),
    .word      (word_q),
    .next_addr (dst_step)
  );

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    rem_d      = rem_q;
    data_d     = data_q;
    rd_seen_d  = rd_seen_q;
    word_d     = word_q;
    src_ctrl_d = src_ctrl_q;
    dst_ctrl_d = dst_ctrl_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_REQ;
          word_d     = new_word;
          src_d      = new_word ? {sad_d[31:2], 2'b00} : {sad_d[31:1], 1'b0};
          dst_d      = new_word ? {dad_d[31:2], 2'b00} : {dad_d[31:1], 1'b0};
          rem_d      = (cnt_l_d == 16'h0) ? 17'h10000 : {1'b0, cnt_l_d};
          src_ctrl_d = cnt_h_d[CNTH_SRC_LO +: 2];
          dst_ctrl_d = cnt_h_d[CNTH_DST_LO +: 2];
        end
      end
      ST_REQ: begin
        rd_seen_d = 1'b0;
        if (dma_gnt) state_d = ST_READ;
      end
      ST_READ: begin
        // Synchronous RAM: data is only trusted after one full granted read cycle.
        if (dma_gnt) begin
          rd_seen_d = 1'b1;
          if (rd_seen_q && bus_ok) begin
            data_d  = word_q ? bus_rdata : {16'h0, bus_rdata[15:0]};
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (dma_gnt && bus_ok) begin
          src_d     = src_step;
          dst_d     = dst_step;
          rem_d     = rem_q - 17'd1;
          rd_seen_d = 1'b0;
          state_d   = (rem_q != 17'd1 && cnt_h_d[CNTH_EN]) ? ST_READ : ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dma_req   = (state_q == ST_REQ) || (state_q == ST_READ) || (state_q == ST_WRITE);
    irq       = (state_q == ST_DONE) && cnt_h_q[CNTH_IRQ];
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    bus_width = 2'd0;
    bus_read  = 1'b0;
    bus_write = 1'b0;
    if (dma_gnt && state_q == ST_READ) begin
      bus_addr  = src_q;
      bus_read  = 1'b1;
      bus_width = word_q ? W_WORD : W_HALF;
    end else if (dma_gnt && state_q == ST_WRITE) begin
      bus_addr  = dst_q;
      bus_write = 1'b1;
      bus_wdata = data_q;
      bus_width = word_q ? W_WORD : W_HALF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sad_q      <= 32'h0;
      dad_q      <= 32'h0;
      cnt_l_q    <= 16'h0;
      cnt_h_q    <= 16'h0;
      state_q    <= ST_IDLE;
      src_q      <= 32'h0;
      dst_q      <= 32'h0;
      rem_q      <= 17'h0;
      data_q     <= 32'h0;
      rd_seen_q  <= 1'b0;
      word_q     <= 1'b0;
      src_ctrl_q <= 2'd0;
      dst_ctrl_q <= 2'd0;
    end else begin
      sad_q      <= sad_d;
      dad_q      <= dad_d;
      cnt_l_q    <= cnt_l_d;
      cnt_h_q    <= cnt_h_d;
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      rd_seen_q  <= rd_seen_d;
      word_q     <= word_d;
      src_ctrl_q <= src_ctrl_d;
      dst_ctrl_q <= dst_ctrl_d;
    end
  end

endmodule
